// File: rtl/div_pkg.sv
// Shared types and constants for the divider sequencer.
//   div_state_e    : sequencer FSM state (IDLE, WAIT, FIX)
//   WORD_W         : operand / result width
//   DIV_BY_ZERO_LO : quotient written when the divisor is zero
package div_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] DIV_BY_ZERO_LO = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// Bus between the register-file/ALU control, the divider sequencer and the
// external combinational divider.
//   start/dividend/divisor        : request from control
//   busy/done/div_by_zero/hi/lo   : status and result registers back to control
//   div_q/div_m                   : operand magnitudes to the divider
//   div_quotient/div_remainder    : unsigned results from the divider
// Handshake: start is a request that is only accepted while busy is low;
// a request seen while busy is high is dropped, not queued. done is a
// single-cycle pulse marking that hi/lo/div_by_zero hold a new result, and
// start may be raised in that same cycle for a back-to-back operation.
interface div_sequencer_if;
  import div_pkg::*;

  logic              start;
  logic [WORD_W-1:0] dividend;
  logic [WORD_W-1:0] divisor;
  logic [WORD_W-1:0] div_q;
  logic [WORD_W-1:0] div_m;
  logic [WORD_W-1:0] div_quotient;
  logic [WORD_W-1:0] div_remainder;
  logic              busy;
  logic              done;
  logic              div_by_zero;
  logic [WORD_W-1:0] hi;
  logic [WORD_W-1:0] lo;

  // Sequencer side.
  modport slave (
    input  start, dividend, divisor, div_quotient, div_remainder,
    output div_q, div_m, busy, done, div_by_zero, hi, lo
  );

  // Control/divider side (bench or surrounding datapath).
  modport master (
    output start, dividend, divisor, div_quotient, div_remainder,
    input  div_q, div_m, busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/div_sign_fix.sv
// Two's-complement conditional negate: y = neg ? -a : a.
// Used to take magnitudes on the way into the divider and to restore signs
// on the way out.
//   neg : negate when high
//   a   : input word
//   y   : result word
module div_sign_fix
  import div_pkg::*;
(
  input  logic              neg,
  input  logic [WORD_W-1:0] a,
  output logic [WORD_W-1:0] y
);

  assign y = neg ? (~a + 1'b1) : a;

endmodule

// File: rtl/div_sequencer.sv
// Multicycle control stage around an external combinational divider.
// Samples signed operands on start, presents their magnitudes to the divider
// for DIV_LATENCY settle cycles, then sign-corrects the results into
// hi (remainder) and lo (quotient) and pulses done.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/result/divider signals (div_sequencer_if.slave)
//   dbg_state  : current FSM state for observation
module div_sequencer
  import div_pkg::*;
#(
  parameter int DIV_LATENCY = 4,
  parameter bit SIGNED      = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  div_sequencer_if.slave     bus,
  output div_state_e         dbg_state
);

  div_state_e        state, state_next;
  logic [3:0]        cnt;
  logic              sign_q, sign_m, zero_div;
  logic [WORD_W-1:0] div_q_r, div_m_r, hi_r, lo_r;
  logic              done_r, dbz_r;

  logic              in_sign_q, in_sign_m;
  logic [WORD_W-1:0] q_mag, m_mag, lo_fixed, hi_fixed, hi_src;

  assign in_sign_q = bus.dividend[WORD_W-1] & SIGNED;
  assign in_sign_m = bus.divisor[WORD_W-1]  & SIGNED;

  div_sign_fix u_fix_q  (.neg(in_sign_q),       .a(bus.dividend),     .y(q_mag));
  div_sign_fix u_fix_m  (.neg(in_sign_m),       .a(bus.divisor),      .y(m_mag));
  div_sign_fix u_fix_lo (.neg(sign_q ^ sign_m), .a(bus.div_quotient), .y(lo_fixed));

  // On a zero divisor hi must return the original dividend, which is the
  // held magnitude with the dividend sign reapplied -- the same fix-up the
  // remainder gets, so the source is simply muxed ahead of one negator.
  assign hi_src = zero_div ? div_q_r : bus.div_remainder;
  div_sign_fix u_fix_hi (.neg(sign_q), .a(hi_src), .y(hi_fixed));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = WAIT;
      WAIT:    if (cnt == 4'd0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      sign_q   <= 1'b0;
      sign_m   <= 1'b0;
      zero_div <= 1'b0;
      div_q_r  <= '0;
      div_m_r  <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
    end else begin
      state  <= state_next;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign_q   <= in_sign_q;
            sign_m   <= in_sign_m;
            div_q_r  <= q_mag;
            div_m_r  <= m_mag;
            zero_div <= (bus.divisor == '0);
            dbz_r    <= 1'b0;
            cnt      <= 4'(DIV_LATENCY - 1);
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        FIX: begin
          lo_r   <= zero_div ? DIV_BY_ZERO_LO : lo_fixed;
          hi_r   <= hi_fixed;
          dbz_r  <= zero_div;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.div_q       = div_q_r;
  assign bus.div_m       = div_m_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.busy        = (state != IDLE);
  assign dbg_state       = state;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
  import div_pkg::*;

  localparam int L       = 4;
  localparam int TIMEOUT = 50;

  logic       clk;
  logic       rst_n;
  div_state_e dbg_state;

  div_sequencer_if bus();

  div_sequencer #(.DIV_LATENCY(L), .SIGNED(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Behavioural stand-in for the combinational unsigned divider.
  always_comb begin
    if (bus.div_m == '0) begin
      bus.div_quotient  = '1;
      bus.div_remainder = bus.div_q;
    end else begin
      bus.div_quotient  = bus.div_q / bus.div_m;
      bus.div_remainder = bus.div_q % bus.div_m;
    end
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];   // {hi, lo} expected per completion

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Pulses start for one edge (E0) and waits for done. lat counts edges from
  // E0 to the edge after which done is seen; bsy counts cycles busy was high.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bsy);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; bsy = 0;
    while (!bus.done && lat < TIMEOUT) begin
      if (bus.busy) bsy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Wait for done from the current point, counting edges.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          lat, bsy, lat2;
    logic [63:0] e;

    vecs[0] = '{"20/3",      32'd20,         32'd3,          32'd6,          32'd2,          1'b0};
    vecs[1] = '{"-20/3",     32'hFFFFFFEC,   32'd3,          32'hFFFFFFFA,   32'hFFFFFFFE,   1'b0};
    vecs[2] = '{"20/-3",     32'd20,         32'hFFFFFFFD,   32'hFFFFFFFA,   32'd2,          1'b0};
    vecs[3] = '{"-20/-4",    32'hFFFFFFEC,   32'hFFFFFFFC,   32'd5,          32'd0,          1'b0};
    vecs[4] = '{"7/0",       32'd7,          32'd0,          32'hFFFFFFFF,   32'd7,          1'b1};
    vecs[5] = '{"20/4",      32'd20,         32'd4,          32'd5,          32'd0,          1'b0};
    vecs[6] = '{"min/-1",    32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[7] = '{"5/10",      32'd5,          32'd10,         32'd0,          32'd5,          1'b0};
    vecs[8] = '{"-7/0",      32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1};
    vecs[9] = '{"min/7",     32'h80000000,   32'd7,          32'hEDB6DB6E,   32'hFFFFFFFE,   1'b0};

    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, bus.busy},        32'd0);
    check("rst_done",  {31'd0, bus.done},        32'd0);
    check("rst_dbz",   {31'd0, bus.div_by_zero}, 32'd0);
    check("rst_hi",    bus.hi,                   32'd0);
    check("rst_lo",    bus.lo,                   32'd0);
    check("rst_div_q", bus.div_q,                32'd0);
    check("rst_div_m", bus.div_m,                32'd0);
    check("rst_state", {30'd0, dbg_state},       {30'd0, IDLE});
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table-driven vectors ----
    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].exp_hi, vecs[i].exp_lo});
      do_op(vecs[i].dividend, vecs[i].divisor, lat, bsy);
      e = exp_q.pop_front();
      check({vecs[i].name, "_lat"},  lat,                          L + 1);
      check({vecs[i].name, "_busy"}, bsy,                          L + 1);
      check({vecs[i].name, "_lo"},   bus.lo,                       e[31:0]);
      check({vecs[i].name, "_hi"},   bus.hi,                       e[63:32]);
      check({vecs[i].name, "_dbz"},  {31'd0, bus.div_by_zero},     {31'd0, vecs[i].exp_dbz});
      check({vecs[i].name, "_bsy_at_done"}, {31'd0, bus.busy},     32'd0);
      @(posedge clk); #1;
      check({vecs[i].name, "_done_pulse"}, {31'd0, bus.done},      32'd0);
      check({vecs[i].name, "_lo_hold"},    bus.lo,                 e[31:0]);
    end

    // ---- start re-pulsed mid-WAIT is ignored ----
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk); #1;                       // E0
    bus.start = 1'b0;
    @(posedge clk); #1;                       // E1
    bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
    check("ign_div_m_stable", bus.div_m, 32'd7);
    @(posedge clk); #1;                       // E2: busy, request dropped
    bus.start = 1'b0;
    check("ign_div_q_stable", bus.div_q, 32'd100);
    wait_done(lat);
    check("ign_lat", lat + 2, L + 1);
    check("ign_lo",  bus.lo,  32'd14);
    check("ign_hi",  bus.hi,  32'd2);
    repeat (L + 3) @(posedge clk);
    #1;
    check("ign_not_queued", {31'd0, bus.busy}, 32'd0);

    // ---- start held high through done: back-to-back ----
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd20; bus.divisor = 32'd3;
    @(posedge clk); #1;                       // E0 of first op
    wait_done(lat);
    check("b2b_lat1", lat,    L + 1);
    check("b2b_lo1",  bus.lo, 32'd6);
    check("b2b_hi1",  bus.hi, 32'd2);
    bus.dividend = 32'd100; bus.divisor = 32'd10;  // start still high
    @(posedge clk); #1;                       // E0 of second op, no dead cycle
    check("b2b_restart", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    wait_done(lat2);
    check("b2b_lat2", lat2,   L + 1);
    check("b2b_lo2",  bus.lo, 32'd10);
    check("b2b_hi2",  bus.hi, 32'd0);

    // ---- asynchronous reset in WAIT aborts ----
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
    @(posedge clk); #1;                       // E0
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;                       // cycle 2 in WAIT
    check("arst_pre_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;                                       // mid-cycle, no clock edge yet
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_hi",   bus.hi,            32'd0);
    check("arst_lo",   bus.lo,            32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (L + 2) @(posedge clk);
    #1;
    check("arst_no_done", {31'd0, bus.done}, 32'd0);
    check("arst_lo_kept", bus.lo,            32'd0);
    do_op(32'd1000, 32'd10, lat, bsy);
    check("post_rst_lat", lat,    L + 1);
    check("post_rst_lo",  bus.lo, 32'd100);
    check("post_rst_hi",  bus.hi, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
